// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command front end: opcodes, instruction layout, mode register,
// and the opcode-to-resource-class decode.
package ats21_pkg;

  localparam int unsigned DefNumClocks = 16;
  localparam int unsigned DefNumAlarms = 24;

  typedef enum logic [2:0] {
    NOP    = 3'b000,
    SETCLK = 3'b001,
    ENCLK  = 3'b010,
    MODE   = 3'b011,
    SETALM = 3'b101,
    SETTMR = 3'b110,
    ENALM  = 3'b111
  } opcode_e;

  // Clock commands use key[4:1] (instruction bits 28:25); alarm commands use all of key.
  typedef struct packed {
    opcode_e     opcode;
    logic [4:0]  key;
    logic [23:0] payload;
  } cmd_t;

  typedef struct packed {
    logic active;
    logic permA_clk;
    logic permB_clk;
    logic permA_alm;
    logic permB_alm;
  } mode_t;

  typedef enum logic [1:0] {
    CLS_CLK,
    CLS_ALM,
    CLS_MODE,
    CLS_BAD
  } class_e;

  function automatic class_e op_class(logic [2:0] op);
    class_e cls;
    case (op)
      3'b001, 3'b010:         cls = CLS_CLK;
      3'b101, 3'b110, 3'b111: cls = CLS_ALM;
      3'b011:                 cls = CLS_MODE;
      default:                cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ats21_cmd_capture.sv
// Per-client instruction capture: collects the top half on an accepted request, the bottom
// half on the following cycle, then holds the word until the arbiter resolves it.
module ats21_cmd_capture
  import ats21_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        ready,
  input  logic [15:0] ctrl,
  input  logic        done,
  output logic        idle,
  output logic        pend,
  output logic [31:0] cmd
);

  typedef enum logic [1:0] {StIdle, StHalf, StPend} state_e;

  state_e      state_q, state_d;
  logic [15:0] top_q, bot_q;
  logic        take_top;

  always_comb begin
    state_d  = state_q;
    take_top = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && ready && (ctrl[15:13] != NOP)) begin
          take_top = 1'b1;
          state_d  = StHalf;
        end
      end
      StHalf:  state_d = StPend;
      StPend:  if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      top_q   <= '0;
      bot_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take_top) top_q <= ctrl;
      if (state_q == StHalf) bot_q <= ctrl;
    end
  end

  assign idle = (state_q == StIdle);
  assign pend = (state_q == StPend);
  assign cmd  = {top_q, bot_q};

endmodule

// File: rtl/ats21_cmd_arbiter.sv
// ATS21 front end: two instruction captures, mode register, conflict and permission checks,
// and a round-robin issue stage onto a single valid/ready command port.
module ats21_cmd_arbiter
  import ats21_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS = DefNumClocks,
  parameter int unsigned NUM_ALARMS = DefNumAlarms
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic        cmd_src
);

  logic [1:0]  idle, pend, done, ok, surv, live;
  logic [1:0]  q_q, q_d, stat_q, stat_d;
  logic [1:0]  perm_clk, perm_alm;
  logic [31:0] word [2];
  cmd_t        c [2];
  class_e      cls [2];
  mode_t       mode_q, mode_d;
  logic        rr_q, rr_d;
  logic        win, resolving, clash, accept;

  ats21_cmd_capture u_cap_a (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ready (ready),
    .ctrl  (ctrlA),
    .done  (done[0]),
    .idle  (idle[0]),
    .pend  (pend[0]),
    .cmd   (word[0])
  );

  ats21_cmd_capture u_cap_b (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ready (ready),
    .ctrl  (ctrlB),
    .done  (done[1]),
    .idle  (idle[1]),
    .pend  (pend[1]),
    .cmd   (word[1])
  );

  assign ready    = &idle;
  assign perm_clk = {mode_q.permB_clk, mode_q.permA_clk};
  assign perm_alm = {mode_q.permB_alm, mode_q.permA_alm};
  // Once survivors are queued every pending client is in q_q, so an empty queue marks resolve.
  assign resolving = (|pend) && !(|q_q);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      c[i]   = cmd_t'(word[i]);
      cls[i] = op_class(c[i].opcode);
    end
    clash = pend[0] && pend[1] && (cls[0] == cls[1]) &&
            (((cls[0] == CLS_CLK) && (c[0].key[4:1] == c[1].key[4:1])) ||
             ((cls[0] == CLS_ALM) && (c[0].key == c[1].key)) ||
             (cls[0] == CLS_MODE));
    for (int i = 0; i < 2; i++) begin
      ok[i] = 1'b0;
      if (pend[i] && !clash) begin
        case (cls[i])
          CLS_CLK:  ok[i] = mode_q.active && perm_clk[i] && (32'(c[i].key[4:1]) < NUM_CLOCKS);
          CLS_ALM:  ok[i] = mode_q.active && perm_alm[i] && (32'(c[i].key) < NUM_ALARMS);
          CLS_MODE: ok[i] = 1'b1;
          default:  ok[i] = 1'b0;
        endcase
      end
      surv[i] = ok[i] && (cls[i] != CLS_MODE);
    end
  end

  assign live      = resolving ? surv : q_q;
  assign win       = (live == 2'b11) ? rr_q : live[1];
  assign cmd_valid = |live;
  assign cmd_data  = cmd_valid ? c[win] : '0;
  assign cmd_src   = cmd_valid && win;
  assign accept    = cmd_valid && cmd_ready;
  assign stat      = stat_q;

  always_comb begin
    q_d    = live;
    stat_d = stat_q;
    mode_d = mode_q;
    rr_d   = rr_q;
    done   = '0;
    for (int i = 0; i < 2; i++) begin
      if (resolving && pend[i] && !surv[i]) begin
        done[i]   = 1'b1;
        stat_d[i] = ok[i];
      end
      if (resolving && ok[i] && (cls[i] == CLS_MODE)) begin
        mode_d.active = c[i].key[4];
        if (i == 0) begin
          mode_d.permA_clk = |c[i].key[3:2];
          mode_d.permA_alm = |c[i].key[1:0];
        end else begin
          mode_d.permB_clk = |c[i].key[3:2];
          mode_d.permB_alm = |c[i].key[1:0];
        end
      end
    end
    if (accept) begin
      q_d[win]    = 1'b0;
      done[win]   = 1'b1;
      stat_d[win] = 1'b1;
      // The pointer only moves when it actually decided between two waiting commands.
      if (live == 2'b11) rr_d = !rr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      stat_q <= '0;
      mode_q <= mode_t'(5'b11111);
      rr_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      stat_q <= stat_d;
      mode_q <= mode_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Self-checking bench for ats21_cmd_arbiter: transaction-level reference model with a
// per-cycle output compare, directed scenarios and randomized traffic.
module tb_ats21_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset, req, cmd_ready;
  logic [15:0] ctrlA, ctrlB;
  logic        ready, cmd_valid, cmd_src;
  logic [1:0]  stat;
  logic [31:0] cmd_data;

  int checks = 0;
  int failures = 0;

  logic        chk_en = 1'b0;
  logic        exp_ready, exp_valid, exp_src;
  logic [31:0] exp_data;
  logic [1:0]  exp_stat;

  // Reference model state.
  logic        m_active, m_rr;
  logic [1:0]  m_pclk, m_palm, m_stat;
  logic [31:0] iss_data [$];
  logic        iss_src [$];

  always #5 clk = ~clk;

  ats21_cmd_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ctrlA     (ctrlA),
    .ctrlB     (ctrlB),
    .ready     (ready),
    .stat      (stat),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_src   (cmd_src)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, ready}, {31'd0, exp_ready});
      chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, exp_valid});
      chk("stat", {30'd0, stat}, {30'd0, exp_stat});
      if (exp_valid) begin
        chk("cmd_data", cmd_data, exp_data);
        chk("cmd_src", {31'd0, cmd_src}, {31'd0, exp_src});
      end
    end
  end

  // 0 clock, 1 alarm, 2 mode, 3 invalid
  function automatic int cls_of(logic [2:0] op);
    case (op)
      3'd1, 3'd2:       return 0;
      3'd5, 3'd6, 3'd7: return 1;
      3'd3:             return 2;
      default:          return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 1'b1;
    m_pclk   = 2'b11;
    m_palm   = 2'b11;
    m_rr     = 1'b0;
    m_stat   = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req       = 1'b0;
    cmd_ready = 1'($urandom);
    ctrlA     = 16'($urandom);
    ctrlB     = 16'($urandom);
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_src   = 1'b0;
    exp_stat  = m_stat;
  endtask

  // rdy_mode: 0 random, 1 always ready, 2 five stall cycles then ready, 3 never ready.
  // abort_at: 0 run to completion, 1 return while halves are being captured,
  //           n>=2 return in the n-th issue-phase cycle.
  task automatic txn(input logic [31:0] wa, input logic [31:0] wb, input int rdy_mode,
                     input int abort_at);
    logic [31:0] w [2];
    int          c [2];
    bit          cap [2];
    bit          okv [2];
    bit          sv [2];
    bit          clash;
    logic [1:0]  nst, cur, npclk, npalm;
    logic        nact, acc;
    logic [31:0] qd [$];
    logic        qs [$];
    int          n;
    w[0] = wa;
    w[1] = wb;
    for (int i = 0; i < 2; i++) begin
      cap[i] = (w[i][31:29] != 3'd0);
      c[i]   = cls_of(w[i][31:29]);
    end
    clash = cap[0] && cap[1] && (c[0] == c[1]) &&
            ((c[0] == 0 && w[0][28:25] == w[1][28:25]) ||
             (c[0] == 1 && w[0][28:24] == w[1][28:24]) || (c[0] == 2));
    nst   = m_stat;
    nact  = m_active;
    npclk = m_pclk;
    npalm = m_palm;
    for (int i = 0; i < 2; i++) begin
      okv[i] = 1'b0;
      sv[i]  = 1'b0;
      if (cap[i]) begin
        okv[i] = !clash &&
                 ((c[i] == 2) ||
                  (c[i] == 0 && m_active && m_pclk[i] && int'(w[i][28:25]) < 16) ||
                  (c[i] == 1 && m_active && m_palm[i] && int'(w[i][28:24]) < 24));
        sv[i] = okv[i] && (c[i] != 2);
        if (!sv[i]) nst[i] = okv[i];
        if (okv[i] && c[i] == 2) begin
          nact     = w[i][28];
          npclk[i] = |w[i][27:26];
          npalm[i] = |w[i][25:24];
        end
      end
    end
    if (sv[0] && sv[1]) begin
      qd.push_back(w[m_rr]);
      qs.push_back(m_rr);
      qd.push_back(w[!m_rr]);
      qs.push_back(!m_rr);
      m_rr = !m_rr;
    end else if (sv[0]) begin
      qd.push_back(w[0]);
      qs.push_back(1'b0);
    end else if (sv[1]) begin
      qd.push_back(w[1]);
      qs.push_back(1'b1);
    end
    iss_data = qd;
    iss_src  = qs;

    req       = 1'b1;
    ctrlA     = wa[31:16];
    ctrlB     = wb[31:16];
    cmd_ready = 1'($urandom);
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_stat  = m_stat;
    step();
    if (!cap[0] && !cap[1]) begin
      drive_idle();
      return;
    end
    req       = 1'($urandom);
    ctrlA     = wa[15:0];
    ctrlB     = wb[15:0];
    cmd_ready = 1'($urandom);
    exp_ready = 1'b0;
    if (abort_at == 1) return;
    step();

    cur = m_stat;
    n   = 0;
    do begin
      exp_valid = (qd.size() > 0);
      exp_data  = exp_valid ? qd[0] : 32'd0;
      exp_src   = exp_valid ? qs[0] : 1'b0;
      exp_ready = 1'b0;
      exp_stat  = cur;
      req       = 1'($urandom);
      ctrlA     = 16'($urandom);
      ctrlB     = 16'($urandom);
      case (rdy_mode)
        1:       cmd_ready = 1'b1;
        2:       cmd_ready = (n >= 5);
        3:       cmd_ready = 1'b0;
        default: cmd_ready = (($urandom % 4) != 0);
      endcase
      acc = exp_valid && cmd_ready;
      n++;
      if (abort_at >= 2 && n >= abort_at) return;
      step();
      if (n == 1) cur = nst;
      if (acc) begin
        cur[qs[0]] = 1'b1;
        void'(qd.pop_front());
        void'(qs.pop_front());
      end
    end while (qd.size() > 0 && n < 1000);
    m_stat   = cur;
    m_active = nact;
    m_pclk   = npclk;
    m_palm   = npalm;
    drive_idle();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_data", cmd_data, 32'd0);
    chk("rst_src", {31'd0, cmd_src}, 32'd0);
    chk("rst_stat", {30'd0, stat}, 32'd0);
    req = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_reset();
    drive_idle();
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] wa, wb;
    req       = 1'b0;
    cmd_ready = 1'b0;
    ctrlA     = '0;
    ctrlB     = '0;
    do_reset();

    // Single SETCLK, clock 5.
    txn(32'h2A40_0010, 32'h0, 1, 0);
    chk("t1_count", iss_data.size(), 1);
    chk("t1_data", iss_data[0], 32'h2A40_0010);
    chk("t1_stat", {30'd0, stat}, 32'h1);
    chk("t1_ready", {31'd0, ready}, 32'd1);

    // Same alarm from both clients.
    txn(32'hA300_0011, 32'hE300_0055, 0, 0);
    chk("t2_count", iss_data.size(), 0);
    chk("t2_stat", {30'd0, stat}, 32'h0);

    // Disjoint resources: A first, then B first on the following pair.
    txn(32'h2200_1234, 32'hA700_0042, 1, 0);
    chk("t3_first_src", {31'd0, iss_src[0]}, 32'd0);
    chk("t3_second_src", {31'd0, iss_src[1]}, 32'd1);
    chk("t3_stat", {30'd0, stat}, 32'h3);
    txn(32'h2200_1234, 32'hA700_0042, 0, 0);
    chk("t3b_first_src", {31'd0, iss_src[0]}, 32'd1);

    // A drops its own alarm permission.
    txn(32'h7C00_0000, 32'h0, 1, 0);
    chk("t4_mode_stat", {30'd0, stat}, 32'h3);
    txn(32'hC200_0000, 32'h0, 1, 0);
    chk("t4_a_count", iss_data.size(), 0);
    chk("t4_a_stat", {30'd0, stat}, 32'h2);
    txn(32'h0, 32'hC200_0001, 1, 0);
    chk("t4_b_count", iss_data.size(), 1);
    chk("t4_b_stat", {30'd0, stat}, 32'h2);
    txn(32'h7F00_0000, 32'h0, 1, 0);

    // Five cycles of back-pressure.
    txn(32'h2A40_0010, 32'h0, 2, 0);
    chk("t5_stat", {30'd0, stat}, 32'h3);

    // Reset while capturing, then while stalled mid-pair.
    txn(32'h2200_0001, 32'hA000_0002, 1, 1);
    do_reset();
    txn(32'h2A40_0010, 32'h0, 1, 0);
    chk("t6_stat", {30'd0, stat}, 32'h1);
    txn(32'h2200_0001, 32'hA000_0002, 3, 3);
    do_reset();
    txn(32'h2200_1234, 32'hA700_0042, 1, 0);
    chk("t6_first_src", {31'd0, iss_src[0]}, 32'd0);
    chk("t6_stat", {30'd0, stat}, 32'h3);

    for (int k = 0; k < 250; k++) begin
      if (k % 25 == 0) begin
        txn(32'h7F00_0000, 32'h0, 0, 0);
        txn(32'h0, 32'h7F00_0000, 0, 0);
      end
      wa = $urandom;
      wb = $urandom;
      if ($urandom % 3 == 0) wb[28:24] = wa[28:24];
      if ($urandom % 4 == 0) wb[31:29] = wa[31:29];
      txn(wa, wb, 0, 0);
    end

    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
